bit_serial_mult: RTL and testbench

- Bit-serial unsigned multiplier for the neural-network accelerator datapath: multiplies an 8-bit neuron activation by a weight delivered one bit per clock, LSB first.
- Produces a scaled, width-limited 8-bit product once per weight word.
- Sits between the weight-stream fetch logic and the neuron accumulator.

---
 rtl/bit_serial_mult_if.sv | 24 ++
 rtl/bit_serial_mult.sv | 74 +++++++
 tb/tb_bit_serial_mult.sv | 116 +++++++++++
 3 files changed

// File: rtl/bit_serial_mult_if.sv
// Operand/weight stream and product result bundle for bit_serial_mult.
// master drives the activation and the serial weight bit; slave returns the product.
interface bit_serial_mult_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] input_neuron;
  logic              Weight_bit;
  logic [DATA_W-1:0] out;
  logic              out_valid;

  modport master (
    output input_neuron,
    output Weight_bit,
    input  out,
    input  out_valid
  );

  modport slave (
    input  input_neuron,
    input  Weight_bit,
    output out,
    output out_valid
  );
endinterface

// File: rtl/bit_serial_mult.sv
// Bit-serial unsigned multiplier: activation x serial weight (LSB first), scaled by OUT_SHIFT.
// Define MULT_OUT_SATURATE_EN to saturate the scaled product instead of truncating it.
module bit_serial_mult #(
  parameter int DATA_W    = 8,
  parameter int WEIGHT_W  = 8,
  parameter int OUT_SHIFT = 4
) (
  input  logic               clk,
  input  logic               reset,
  bit_serial_mult_if.slave   bus
);
  localparam int ACC_W = DATA_W + WEIGHT_W;
  localparam int CNT_W = (WEIGHT_W > 1) ? $clog2(WEIGHT_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WEIGHT_W - 1);

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ACC_W-1:0]  acc_reg, acc_next;
  logic [DATA_W-1:0] op_reg, op_next;
  logic [DATA_W-1:0] out_reg, out_next;
  logic              valid_reg, valid_next;

  logic [DATA_W-1:0] op_cur;
  logic [ACC_W-1:0]  pp [WEIGHT_W];
  logic [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]  scaled;
  logic [DATA_W-1:0] limited;
  logic              last_bit;

  // Bit 0 uses the live activation so the first partial product needs no extra cycle.
  assign op_cur = (cnt_reg == '0) ? bus.input_neuron : op_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WEIGHT_W; gi++) begin : g_pp
      assign pp[gi] = {{WEIGHT_W{1'b0}}, op_cur} << gi;
    end
  endgenerate

  always_comb begin
    last_bit = (cnt_reg == LAST_BIT);
    sum      = acc_reg + (bus.Weight_bit ? pp[cnt_reg] : '0);
    scaled   = sum >> OUT_SHIFT;
`ifdef MULT_OUT_SATURATE_EN
    limited  = (|scaled[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : scaled[DATA_W-1:0];
`else
    limited  = scaled[DATA_W-1:0];
`endif

    cnt_next   = last_bit ? '0 : cnt_reg + 1'b1;
    acc_next   = last_bit ? '0 : sum;
    op_next    = (cnt_reg == '0) ? bus.input_neuron : op_reg;
    out_next   = last_bit ? limited : out_reg;
    valid_next = last_bit;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg   <= '0;
      acc_reg   <= '0;
      op_reg    <= '0;
      out_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      acc_reg   <= acc_next;
      op_reg    <= op_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = valid_reg;
endmodule

// File: tb/tb_bit_serial_mult.sv
// Self-checking bench for bit_serial_mult: directed words from the test plan plus random words,
// compared cycle by cycle against a word-level arithmetic reference.
module tb_bit_serial_mult;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bit_serial_mult_if #(.DATA_W(8)) bus ();

  bit_serial_mult #(
    .DATA_W   (8),
    .WEIGHT_W (8),
    .OUT_SHIFT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_out;
  logic       exp_valid;

  function automatic logic [7:0] limit_ref(input int unsigned p);
    int unsigned s;
    s = p >> 4;
`ifdef MULT_OUT_SATURATE_EN
    return (s > 255) ? 8'd255 : 8'(s);
`else
    return 8'(s % 256);
`endif
  endfunction

  task automatic check_outputs(input string tag);
    checks++;
    assert (bus.out_valid === exp_valid)
    else begin
      fails++;
      $error("FAIL %s out_valid got %b want %b", tag, bus.out_valid, exp_valid);
    end
    checks++;
    assert (bus.out === exp_out)
    else begin
      fails++;
      $error("FAIL %s out got %0d want %0d", tag, bus.out, exp_out);
    end
  endtask

  // Check what the previous edge produced, then present this cycle's inputs.
  task automatic step(input logic rst, input logic [7:0] inn, input logic wb, input string tag);
    @(negedge clk);
    check_outputs(tag);
    reset            = rst;
    bus.input_neuron = inn;
    bus.Weight_bit   = wb;
  endtask

  // Send nbits of weight w; from bit chg_bit onward the activation input shows chg_val.
  task automatic run_word(input logic [7:0] op, input logic [7:0] w, input int nbits,
                          input int chg_bit, input logic [7:0] chg_val, input string tag);
    logic [7:0] inn;
    for (int k = 0; k < nbits; k++) begin
      inn = (k == 0) ? op : ((k >= chg_bit) ? chg_val : op);
      step(1'b1, inn, w[k], tag);
      if (k == 7) begin
        exp_valid = 1'b1;
        exp_out   = limit_ref(int'(op) * int'(w));
      end else begin
        exp_valid = 1'b0;
      end
    end
    if (nbits == 8)
      $display("word %s op=%0d w=%0d expect_out=%0d", tag, op, w, exp_out);
    else
      $display("word %s op=%0d w=%0d aborted after %0d bits", tag, op, w, nbits);
  endtask

  task automatic reset_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 8'($urandom), 1'($urandom), tag);
      exp_valid = 1'b0;
      exp_out   = 8'd0;
    end
    $display("reset %s cycles=%0d", tag, n);
  endtask

  initial begin
    reset            = 1'b0;
    bus.input_neuron = 8'd0;
    bus.Weight_bit   = 1'b0;
    exp_out          = 8'd0;
    exp_valid        = 1'b0;
    @(posedge clk);

    reset_cycles(2, "por");
    run_word(8'd105, 8'd17, 8, 8, 8'd0, "w17");
    run_word(8'd105, 8'd1, 8, 1, 8'd200, "w1");
    run_word(8'd105, 8'd0, 8, 1, 8'd77, "w0");
    run_word(8'd255, 8'd255, 8, 8, 8'd0, "max");
    run_word(8'd105, 8'd17, 8, 3, 8'd0, "midchg");
    run_word(8'd200, 8'd255, 3, 8, 8'd0, "abort");
    reset_cycles(2, "abort_rst");
    run_word(8'd32, 8'd1, 8, 8, 8'd0, "after_abort");

    for (int i = 0; i < 40; i++)
      run_word(8'($urandom), 8'($urandom), 8, int'($urandom_range(1, 7)), 8'($urandom), "rand");

    step(1'b1, 8'd0, 1'b0, "drain");
    exp_valid = 1'b0;
    step(1'b1, 8'd0, 1'b0, "idle");

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
